alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, multi-cycle successor of the 8-bit datapath ALU, sitting between the A register and the shared data bus. It adds operand width as a parameter, an OR op, and add-with-carry. It also adds an iterative shift-add multiplier that returns a double-width product, with a start/busy/done handshake for the multi-cycle operation. Single-cycle ops keep the existing bus contract: the result is registered and driven to the bus under output-enable control.

## Interface
- `WIDTH`, default 8: operand/result width. Must be a power of two, ≥4.
- `SHW`, default `$clog2(WIDTH)`: width of the shift-amount field. Derived; not overridden.
- `i_clk`, in, 1: clock. All state updates on the rising edge.
- `i_resetN`, in, 1: reset, asynchronous, active-low.
- `i_a`, in, WIDTH: operand A.
- `i_bus`, in, WIDTH: operand B. Shift ops use `i_bus[SHW-1:0]` as the shift amount.
- `o_bus`, out, WIDTH: result register Y.
- `o_busNOE`, out, 1: direct pass-through of `i_ctrlAluNOE`.
- `o_hi`, out, WIDTH: high half of the last MUL product. Cleared by reset only.
- `o_flagNegative`, `o_flagZero`, `o_flagOverflow`, `o_flagCarry`, out, 1 each: registered flags.
- `o_busy`, out, 1: multiplier running.
- `o_done`, out, 1: one-cycle pulse when Y/flags were written.
- `i_ctrlAluYNWE`, in, 1: active-low op start/write request.
- `i_ctrlAluNOE`, in, 1: active-low bus output enable.
- `i_ctrlAluSub`, in, 1: subtract for ADD; left shift for SHIFT; ignored otherwise.
- `i_ctrlAluCarry`, in, 1: use `o_flagCarry` as carry-in for ADD (ADC/SBC).
- `i_ctrlAluOp`, in, 3: 000 ADD, 001 AND, 010 XOR, 011 SHIFT, 100 OR, 101 MUL. 110 and 111 are reserved and behave as NOP: no write, no `o_done`.

## Operation
- FSM states are IDLE and MUL. A request is `i_ctrlAluYNWE==0` sampled in IDLE. Requests while in MUL are ignored.
- **Reset values:** Y, `o_hi`, all flags, `o_busy` and `o_done` are 0; FSM enters IDLE. Reset during MUL aborts the operation with no write.
- **ADD:** B' = `i_bus` XOR {WIDTH{Sub}}. cin0 = Carry ? `o_flagCarry` : Sub. Y = A + B' + cin0.
  - C = carry out of bit WIDTH-1.
  - V = carry into MSB XOR carry out of MSB.
  - Subtract: C=1 means no borrow.
- **AND, XOR, OR:** bitwise A op `i_bus`; C=0, V=0. Sub does not invert B.
- **SHIFT:** logical shift of A by n = `i_bus[SHW-1:0]`, zero fill. Sub=0 shifts right, Sub=1 shifts left.
  - Right: C = A[n-1]. Left: C = A[WIDTH-n].
  - n=0: Y=A and C unchanged.
  - V=0.
- **All single-cycle ops:** N = Y[WIDTH-1]; Z = (Y==0).
- **MUL:** unsigned A×`i_bus`; operands are latched on request.
  - One shift-add step per cycle, WIDTH steps.
  - Then Y = product low half, `o_hi` = product high half.
  - N = product MSB; Z = (full product == 0); C = (high half != 0); V = 0.
- Y and flags change only on a completed op; `o_hi` changes only on a MUL write.

## Timing
- **Single-cycle op:** request sampled at edge k → Y/flags valid and `o_done`=1 after edge k, for one cycle.
- **MUL:** request at edge k.
  - `o_busy`=1 after edge k through edge k+WIDTH-1.
  - Result, `o_hi`, flags and `o_done` written at edge k+WIDTH, and `o_busy` drops at the same edge.
  - A new request is accepted at edge k+WIDTH+1 at the earliest.
- Back-to-back single-cycle requests are accepted every cycle.
- `o_bus` always shows register Y; `o_busNOE` is combinational from `i_ctrlAluNOE`, with zero latency.

## Structure
- Package `alu_pkg`: op-code localparams (`ALU_ADD`…`ALU_MUL`), FSM state encoding, and the WIDTH legality check.
- Sub-module `alu_mul_seq`, the iterative multiplier.
  - Ports: `i_clk`, `i_resetN`, start, operands, busy, done, product[2*WIDTH].
  - The top level owns Y, flags and the FSM handshake.
- Adder, logic ops and barrel shifter stay combinational in the top level.

## Test plan
- **WIDTH=8, ADD:** A=0x7F, B=0x01 → Y=0x80, N=1, V=1, C=0, Z=0, `o_done` one cycle.
- **SUB:** A=0x05, B=0x05 → Y=0x00, Z=1, C=1.
  - Then Carry=1 with C=1: ADD A=0xFF, B=0x00 → Y=0x00, C=1, Z=1.
- **SHIFT:** A=0x81.
  - n=1 right → Y=0x40, C=1.
  - n=1 left → Y=0x02, C=1.
  - n=0 with C preset to 0 → Y=0x81, C=0.
- **MUL:** A=0x10, B=0x20 → `o_busy` for 8 cycles, then Y=0x00, `o_hi`=0x02, C=1, Z=0.
  - A request issued mid-MUL is ignored.
  - A=0x00 → Z=1.
- **Reset abort:** assert `i_resetN`=0 at cycle 3 of MUL → Y, `o_hi`, flags, `o_busy` all 0 immediately, with no `o_done`.
- **Reserved op 110 and WIDTH=16 regression:** op 110 → no write, no `o_done`. WIDTH=16 ADD 0xFFFF+0x0001 → Y=0, C=1, Z=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - op-code localparams for i_ctrlAluOp
//   - FSM state encoding for the request/multiply handshake
//   - width_ok(): legality check for the WIDTH parameter
package alu_pkg;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_AND   = 3'b001;
  localparam logic [2:0] ALU_XOR   = 3'b010;
  localparam logic [2:0] ALU_SHIFT = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_MUL   = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

  // Operand width must be a power of two and at least 4.
  function automatic bit width_ok(input int w);
    return (w >= 4) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand, control, result and flag signals of alu_seq.
//   master modport: the sequencer side (drives operands/controls).
//   slave  modport: the ALU side (drives result, flags, busy/done).
// Clock and reset are kept as plain module ports.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_bus;
  logic [WIDTH-1:0] o_bus;
  logic             o_busNOE;
  logic [WIDTH-1:0] o_hi;
  logic             o_flagNegative;
  logic             o_flagZero;
  logic             o_flagOverflow;
  logic             o_flagCarry;
  logic             o_busy;
  logic             o_done;
  logic             i_ctrlAluYNWE;
  logic             i_ctrlAluNOE;
  logic             i_ctrlAluSub;
  logic             i_ctrlAluCarry;
  logic [2:0]       i_ctrlAluOp;

  modport master (
    output i_a, i_bus, i_ctrlAluYNWE, i_ctrlAluNOE, i_ctrlAluSub,
           i_ctrlAluCarry, i_ctrlAluOp,
    input  o_bus, o_busNOE, o_hi, o_flagNegative, o_flagZero,
           o_flagOverflow, o_flagCarry, o_busy, o_done
  );

  modport slave (
    input  i_a, i_bus, i_ctrlAluYNWE, i_ctrlAluNOE, i_ctrlAluSub,
           i_ctrlAluCarry, i_ctrlAluOp,
    output o_bus, o_busNOE, o_hi, o_flagNegative, o_flagZero,
           o_flagOverflow, o_flagCarry, o_busy, o_done
  );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative unsigned shift-add multiplier, one partial
// product per clock, WIDTH steps in total.
//   i_clk, i_resetN : clock, asynchronous active-low reset
//   start           : latch a/b and perform the first step this edge
//   a, b            : operands
//   busy            : a multiplication is in progress
//   done            : all steps complete; product is final this cycle and
//                     the unit returns to idle on the next edge
//   product         : 2*WIDTH-bit accumulator / result
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_resetN,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CW-1:0]      count_reg;
  logic               run_reg;
  logic               last_step;

  assign last_step = run_reg && (count_reg == CW'(WIDTH));

  // The first step is folded into the start edge, so after WIDTH-1
  // further edges the product is complete and done is raised for the
  // cycle in which the caller consumes it.
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      run_reg    <= 1'b0;
    end else if (start && !run_reg) begin
      acc_reg    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_reg  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier_reg <= {1'b0, b[WIDTH-1:1]};
      count_reg  <= CW'(1);
      run_reg    <= 1'b1;
    end else if (run_reg) begin
      if (last_step) begin
        run_reg <= 1'b0;
      end else begin
        acc_reg    <= acc_reg + (mplier_reg[0] ? mcand_reg : '0);
        mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
        mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
        count_reg  <= count_reg + 1'b1;
      end
    end
  end

  assign busy    = run_reg;
  assign done    = last_step;
  assign product = acc_reg;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: parametrised multi-cycle ALU between the A register and the
// shared data bus.
//   i_clk, i_resetN : clock, asynchronous active-low reset
//   bus (slave)     : operands i_a/i_bus, controls i_ctrlAlu*, result
//                     o_bus (register Y), o_hi, flags N/Z/V/C,
//                     o_busy, o_done, o_busNOE (pass-through of NOE)
// Single-cycle ops (ADD/AND/XOR/SHIFT/OR) write Y and flags on the
// request edge; MUL hands off to alu_mul_seq and writes WIDTH edges later.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic    i_clk,
  input  logic    i_resetN,
  alu_seq_if.slave bus
);

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("alu_seq: WIDTH must be a power of two and >= 4");
    end
  endgenerate

  alu_state_t state_reg, state_next;

  logic [WIDTH-1:0] y_reg;
  logic [WIDTH-1:0] hi_reg;
  logic             n_reg, z_reg, v_reg, c_reg;
  logic             done_reg;

  logic             req;
  logic             wr_single;
  logic             wr_mul;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [2*WIDTH-1:0] product;

  // Combinational datapath
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   shr_ext;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH-1:0] y_alu;
  logic             c_alu;
  logic             v_alu;
  logic             single_op;

  assign req = !bus.i_ctrlAluYNWE;

  always_comb begin
    b_eff   = bus.i_bus ^ {WIDTH{bus.i_ctrlAluSub}};
    cin     = bus.i_ctrlAluCarry ? c_reg : bus.i_ctrlAluSub;
    sum     = {1'b0, bus.i_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    shamt   = bus.i_bus[SHW-1:0];
    // A guard bit below (right) / above (left) the operand catches the
    // last bit shifted out, giving C without a variable index.
    shr_ext = {bus.i_a, 1'b0} >> shamt;
    shl_ext = {1'b0, bus.i_a} << shamt;

    y_alu     = '0;
    c_alu     = 1'b0;
    v_alu     = 1'b0;
    single_op = 1'b1;
    case (bus.i_ctrlAluOp)
      ALU_ADD: begin
        y_alu = sum[WIDTH-1:0];
        c_alu = sum[WIDTH];
        // carry into the MSB xor carry out of the MSB
        v_alu = (bus.i_a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
      end
      ALU_AND: y_alu = bus.i_a & bus.i_bus;
      ALU_XOR: y_alu = bus.i_a ^ bus.i_bus;
      ALU_OR:  y_alu = bus.i_a | bus.i_bus;
      ALU_SHIFT: begin
        if (bus.i_ctrlAluSub) begin
          y_alu = shl_ext[WIDTH-1:0];
          c_alu = (shamt == '0) ? c_reg : shl_ext[WIDTH];
        end else begin
          y_alu = shr_ext[WIDTH:1];
          c_alu = (shamt == '0) ? c_reg : shr_ext[0];
        end
      end
      ALU_MUL: single_op = 1'b0;
      default: single_op = 1'b0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) state_reg <= ST_IDLE;
    else           state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req && bus.i_ctrlAluOp == ALU_MUL) state_next = ST_MUL;
      ST_MUL:  if (mul_done) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs (write strobes); requests in ST_MUL are ignored
  always_comb begin
    wr_single = 1'b0;
    wr_mul    = 1'b0;
    mul_start = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        wr_single = req && single_op;
        mul_start = req && (bus.i_ctrlAluOp == ALU_MUL);
      end
      ST_MUL:  wr_mul = mul_done;
      default: ;
    endcase
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .i_clk    (i_clk),
    .i_resetN (i_resetN),
    .start    (mul_start),
    .a        (bus.i_a),
    .b        (bus.i_bus),
    .busy     (mul_busy),
    .done     (mul_done),
    .product  (product)
  );

  // Result and flag registers
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      y_reg    <= '0;
      hi_reg   <= '0;
      n_reg    <= 1'b0;
      z_reg    <= 1'b0;
      v_reg    <= 1'b0;
      c_reg    <= 1'b0;
      done_reg <= 1'b0;
    end else if (wr_single) begin
      y_reg    <= y_alu;
      n_reg    <= y_alu[WIDTH-1];
      z_reg    <= (y_alu == '0);
      v_reg    <= v_alu;
      c_reg    <= c_alu;
      done_reg <= 1'b1;
    end else if (wr_mul) begin
      y_reg    <= product[WIDTH-1:0];
      hi_reg   <= product[2*WIDTH-1:WIDTH];
      n_reg    <= product[2*WIDTH-1];
      z_reg    <= (product == '0);
      v_reg    <= 1'b0;
      c_reg    <= (product[2*WIDTH-1:WIDTH] != '0);
      done_reg <= 1'b1;
    end else begin
      done_reg <= 1'b0;
    end
  end

  assign bus.o_bus          = y_reg;
  assign bus.o_busNOE       = bus.i_ctrlAluNOE;
  assign bus.o_hi           = hi_reg;
  assign bus.o_flagNegative = n_reg;
  assign bus.o_flagZero     = z_reg;
  assign bus.o_flagOverflow = v_reg;
  assign bus.o_flagCarry    = c_reg;
  // Mirrors the multiplier's busy; both are cleared by the same reset
  // and the same completion edge.
  assign bus.o_busy         = (state_reg == ST_MUL) && mul_busy;
  assign bus.o_done         = done_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed expectations for
// alu_seq at WIDTH=8 and WIDTH=16.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  if8 ();
  alu_seq_if #(.WIDTH(16)) if16 ();

  alu_seq #(.WIDTH(8)) dut8 (
    .i_clk    (clk),
    .i_resetN (rst_n),
    .bus      (if8.slave)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .i_clk    (clk),
    .i_resetN (rst_n),
    .bus      (if16.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] f8, f16;  // {N,Z,V,C}
  assign f8  = {if8.o_flagNegative, if8.o_flagZero, if8.o_flagOverflow, if8.o_flagCarry};
  assign f16 = {if16.o_flagNegative, if16.o_flagZero, if16.o_flagOverflow, if16.o_flagCarry};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request edge on the 8-bit instance.
  task automatic op8(input logic [2:0] op, input logic sub, input logic carry,
                     input logic [7:0] a, input logic [7:0] b);
    if8.i_ctrlAluOp    = op;
    if8.i_ctrlAluSub   = sub;
    if8.i_ctrlAluCarry = carry;
    if8.i_a            = a;
    if8.i_bus          = b;
    if8.i_ctrlAluYNWE  = 1'b0;
    tick();
    if8.i_ctrlAluYNWE  = 1'b1;
  endtask

  task automatic expect8(input string tag, input logic [7:0] y, input logic [3:0] f,
                         input logic done);
    check({tag, " y"}, {24'd0, if8.o_bus}, {24'd0, y});
    check({tag, " nzvc"}, {28'd0, f8}, {28'd0, f});
    check({tag, " done"}, {31'd0, if8.o_done}, {31'd0, done});
  endtask

  // MUL on the 8-bit instance; optional ADD request injected mid-run.
  task automatic mul8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] y_before, input bit poke);
    op8(ALU_MUL, 1'b0, 1'b0, a, b);
    check({tag, " busy k"}, {31'd0, if8.o_busy}, 32'd1);
    check({tag, " done k"}, {31'd0, if8.o_done}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      if (poke && i == 3) begin
        if8.i_ctrlAluOp   = ALU_ADD;
        if8.i_a           = 8'h01;
        if8.i_bus         = 8'h01;
        if8.i_ctrlAluYNWE = 1'b0;
      end
      tick();
      if8.i_ctrlAluYNWE = 1'b1;
      check($sformatf("%s busy k+%0d", tag, i), {31'd0, if8.o_busy}, 32'd1);
      check($sformatf("%s done k+%0d", tag, i), {31'd0, if8.o_done}, 32'd0);
    end
    check({tag, " y held"}, {24'd0, if8.o_bus}, {24'd0, y_before});
    tick();
    check({tag, " busy end"}, {31'd0, if8.o_busy}, 32'd0);
  endtask

  initial begin
    int n;
    bit seen_done;

    rst_n = 1'b0;
    if8.i_a = '0;  if8.i_bus = '0;  if8.i_ctrlAluOp = '0;
    if8.i_ctrlAluYNWE = 1'b1; if8.i_ctrlAluNOE = 1'b1;
    if8.i_ctrlAluSub = 1'b0;  if8.i_ctrlAluCarry = 1'b0;
    if16.i_a = '0; if16.i_bus = '0; if16.i_ctrlAluOp = '0;
    if16.i_ctrlAluYNWE = 1'b1; if16.i_ctrlAluNOE = 1'b1;
    if16.i_ctrlAluSub = 1'b0;  if16.i_ctrlAluCarry = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    expect8("reset", 8'h00, 4'b0000, 1'b0);
    check("reset hi", {24'd0, if8.o_hi}, 32'd0);
    check("reset busy", {31'd0, if8.o_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ADD with signed overflow
    op8(ALU_ADD, 1'b0, 1'b0, 8'h7F, 8'h01);
    expect8("add 7f+01", 8'h80, 4'b1010, 1'b1);
    tick();
    check("add done pulse", {31'd0, if8.o_done}, 32'd0);

    // SUB equal operands: C=1 means no borrow
    op8(ALU_ADD, 1'b1, 1'b0, 8'h05, 8'h05);
    expect8("sub 05-05", 8'h00, 4'b0101, 1'b1);
    // ADC using C=1 as carry-in
    op8(ALU_ADD, 1'b0, 1'b1, 8'hFF, 8'h00);
    expect8("adc ff+00+1", 8'h00, 4'b0101, 1'b1);

    // SHIFT
    op8(ALU_SHIFT, 1'b0, 1'b0, 8'h81, 8'h01);
    expect8("shr 81>>1", 8'h40, 4'b0001, 1'b1);
    op8(ALU_SHIFT, 1'b1, 1'b0, 8'h81, 8'h01);
    expect8("shl 81<<1", 8'h02, 4'b0001, 1'b1);
    op8(ALU_AND, 1'b0, 1'b0, 8'h81, 8'h00);
    expect8("and clears c", 8'h00, 4'b0100, 1'b1);
    op8(ALU_SHIFT, 1'b0, 1'b0, 8'h81, 8'h00);
    expect8("shr n=0", 8'h81, 4'b1000, 1'b1);
    op8(ALU_SHIFT, 1'b1, 1'b0, 8'hC3, 8'h03);
    expect8("shl c3<<3", 8'h18, 4'b0000, 1'b1);

    // Back-to-back XOR then OR (Sub must not invert B for OR)
    if8.i_ctrlAluOp = ALU_XOR; if8.i_ctrlAluSub = 1'b0;
    if8.i_a = 8'hF0; if8.i_bus = 8'hFF; if8.i_ctrlAluYNWE = 1'b0;
    tick();
    expect8("b2b xor", 8'h0F, 4'b0000, 1'b1);
    if8.i_ctrlAluOp = ALU_OR; if8.i_ctrlAluSub = 1'b1;
    if8.i_a = 8'h0F; if8.i_bus = 8'h30;
    tick();
    if8.i_ctrlAluYNWE = 1'b1;
    expect8("b2b or", 8'h3F, 4'b0000, 1'b1);

    // MUL 0x10 * 0x20 = 0x0200, with an ignored request mid-run
    mul8("mul 10x20", 8'h10, 8'h20, 8'h3F, 1'b1);
    expect8("mul 10x20", 8'h00, 4'b0001, 1'b1);
    check("mul 10x20 hi", {24'd0, if8.o_hi}, 32'h02);
    tick();
    check("mul after done", {31'd0, if8.o_done}, 32'd0);
    check("mul after busy", {31'd0, if8.o_busy}, 32'd0);

    mul8("mul ffxff", 8'hFF, 8'hFF, 8'h00, 1'b0);
    expect8("mul ffxff", 8'h01, 4'b1001, 1'b1);
    check("mul ffxff hi", {24'd0, if8.o_hi}, 32'hFE);

    mul8("mul 00x20", 8'h00, 8'h20, 8'h01, 1'b0);
    expect8("mul 00x20", 8'h00, 4'b0100, 1'b1);
    check("mul 00x20 hi", {24'd0, if8.o_hi}, 32'h00);

    // Leave nonzero state, then reset during MUL
    mul8("mul 13x11", 8'h13, 8'h11, 8'h00, 1'b0);
    expect8("mul 13x11", 8'h43, 4'b0001, 1'b1);
    check("mul 13x11 hi", {24'd0, if8.o_hi}, 32'h01);
    op8(ALU_MUL, 1'b0, 1'b0, 8'h10, 8'h20);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    expect8("abort", 8'h00, 4'b0000, 1'b0);
    check("abort hi", {24'd0, if8.o_hi}, 32'd0);
    check("abort busy", {31'd0, if8.o_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (if8.o_done) seen_done = 1'b1;
    end
    check("abort no done", {31'd0, seen_done}, 32'd0);
    check("abort y", {24'd0, if8.o_bus}, 32'd0);

    // Reserved op-codes are NOPs
    op8(ALU_ADD, 1'b0, 1'b0, 8'h01, 8'h01);
    expect8("add 01+01", 8'h02, 4'b0000, 1'b1);
    op8(3'b110, 1'b0, 1'b0, 8'h55, 8'h55);
    expect8("op110", 8'h02, 4'b0000, 1'b0);
    op8(3'b111, 1'b1, 1'b0, 8'h80, 8'h80);
    expect8("op111", 8'h02, 4'b0000, 1'b0);

    // Output-enable pass-through
    if8.i_ctrlAluNOE = 1'b0;
    #1;
    check("noe low", {31'd0, if8.o_busNOE}, 32'd0);
    if8.i_ctrlAluNOE = 1'b1;
    #1;
    check("noe high", {31'd0, if8.o_busNOE}, 32'd1);

    // WIDTH=16
    if16.i_ctrlAluOp = ALU_ADD; if16.i_a = 16'hFFFF; if16.i_bus = 16'h0001;
    if16.i_ctrlAluYNWE = 1'b0;
    @(negedge clk);
    tick();
    if16.i_ctrlAluYNWE = 1'b1;
    check("w16 add y", {16'd0, if16.o_bus}, 32'h0000);
    check("w16 add nzvc", {28'd0, f16}, 32'b0101);
    check("w16 add done", {31'd0, if16.o_done}, 32'd1);

    if16.i_ctrlAluOp = ALU_MUL; if16.i_a = 16'h1234; if16.i_bus = 16'h0100;
    if16.i_ctrlAluYNWE = 1'b0;
    tick();
    if16.i_ctrlAluYNWE = 1'b1;
    n = 0;
    while (if16.o_busy && n < 40) begin
      tick();
      n++;
    end
    check("w16 mul cycles", n, 32'd16);
    check("w16 mul y", {16'd0, if16.o_bus}, 32'h3400);
    check("w16 mul hi", {16'd0, if16.o_hi}, 32'h0012);
    check("w16 mul nzvc", {28'd0, f16}, 32'b0001);
    check("w16 mul done", {31'd0, if16.o_done}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
